// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port shared by the loader
// and whatever feeds it the boot image.
interface imem_loader_if #(
    parameter int AW = 6
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  we,
        input  wa,
        input  wd
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output we,
        output wa,
        output wd
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a length-prefixed byte stream and
// writes MSB-first 32-bit words to consecutive addresses while holding the CPU.
module imem_loader #(
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         cpu_hold
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic [AW:0]   len;
    logic [1:0]    byte_cnt;
    logic [23:0]   shift;

    logic xfer;
    logic len_ok;
    logic last_word;

    assign xfer      = bus.in_valid && bus.in_ready;
    assign len_ok    = (bus.in_data != 8'd0) && ({1'b0, bus.in_data} <= 9'(DEPTH));
    // One extra bit so that a full-depth image ends cleanly instead of wrapping.
    assign last_word = (({1'b0, addr} + (AW+1)'(1)) == len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            addr         <= '0;
            len          <= '0;
            byte_cnt     <= '0;
            shift        <= '0;
            bus.in_ready <= 1'b0;
            bus.we       <= 1'b0;
            bus.wa       <= '0;
            bus.wd       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_hold     <= 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state        <= S_LEN;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        cpu_hold     <= 1'b1;
                    end
                end

                S_LEN: begin
                    if (xfer) begin
                        if (len_ok) begin
                            state    <= S_DATA;
                            len      <= bus.in_data[AW:0];
                            addr     <= '0;
                            byte_cnt <= '0;
                        end else begin
                            state        <= S_ERR;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b0;
                            err          <= 1'b1;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        shift <= {shift[15:0], bus.in_data};
                        // The fourth byte goes straight to the write port, so only
                        // the first three need to be buffered.
                        if (byte_cnt == 2'd3) begin
                            state        <= S_WRITE;
                            bus.in_ready <= 1'b0;
                            bus.we       <= 1'b1;
                            bus.wa       <= addr;
                            bus.wd       <= {shift, bus.in_data};
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end

                S_WRITE: begin
                    bus.we <= 1'b0;
                    addr   <= addr + AW'(1);
                    if (last_word) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state        <= S_DATA;
                        byte_cnt     <= '0;
                        bus.in_ready <= 1'b1;
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    bus.in_ready <= 1'b0;
                    bus.we       <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed loads push expected writes into a
// queue, and a negedge monitor pops and compares every we pulse.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic busy;
    logic done;
    logic err;
    logic cpu_hold;

    imem_loader_if #(.AW(6)) ifc ();

    imem_loader #(
        .AW   (6),
        .DEPTH(64)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bus     (ifc.slave),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t sbQ[$];
    wr_t expWr;
    int  totalChecks  = 0;
    int  passedChecks = 0;
    int  cycle        = 0;
    int  lenCycle     = 0;
    bit  gapMode      = 1'b0;
    int  latency;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual === expected) passedChecks++;
        else $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    endtask

    // Every write the DUT issues must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ifc.we === 1'b1) begin
            checkOutput("in_ready_during_write", 32'(ifc.in_ready), 32'd0);
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_we", 32'd1, 32'd0);
            end else begin
                expWr = sbQ.pop_front();
                checkOutput("wa", 32'(ifc.wa), 32'(expWr.a));
                checkOutput("wd", ifc.wd, expWr.d);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input bit pulseStart);
        bit accepted = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        start        = pulseStart;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            accepted = ifc.in_ready;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (!accepted) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
        if (gapMode) begin
            ifc.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendWord(input logic [5:0] a, input logic [31:0] d, input int startAt);
        sbQ.push_back('{a: a, d: d});
        for (int k = 0; k < 4; k++) applyStimulus(d[31-8*k -: 8], (k == startAt));
    endtask

    task automatic startLoad();
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lenCycle = cycle;
    endtask

    task automatic endStream();
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
    endtask

    task automatic waitFinish(output int lat);
        int n = 0;
        while (!(done || err) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!(done || err)) checkOutput("finish_timeout", 32'd0, 32'd1);
        lat = cycle - lenCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic checkSuccess(input string tag);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_sb_drained"}, 32'(sbQ.size()), 32'd0);
    endtask

    task automatic badLength(input logic [7:0] l, input string tag);
        startLoad();
        applyStimulus(l, 1'b0);
        endStream();
        waitFinish(latency);
        repeat (3) @(negedge clk);
        checkOutput({tag, "_err"}, 32'(err), 32'd1);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(ifc.in_ready), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(ifc.in_ready), 32'd0);
        checkOutput({tag, "_we"}, 32'(ifc.we), 32'd0);
        checkOutput({tag, "_wa"}, 32'(ifc.wa), 32'd0);
        checkOutput({tag, "_wd"}, ifc.wd, 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] two-word load, in_valid held high");
        startLoad();
        checkOutput("len_in_ready", 32'(ifc.in_ready), 32'd1);
        checkOutput("len_busy", 32'(busy), 32'd1);
        applyStimulus(8'd2, 1'b0);
        sendWord(6'd0, 32'h8C010000, -1);
        sendWord(6'd1, 32'h20020005, -1);
        endStream();
        waitFinish(latency);
        checkOutput("two_word_latency", 32'(latency), 32'd11);
        checkSuccess("two_word");

        $display("[TB] two-word load, in_valid toggling");
        gapMode = 1'b1;
        startLoad();
        checkOutput("restart_done_cleared", 32'(done), 32'd0);
        checkOutput("restart_cpu_hold", 32'(cpu_hold), 32'd1);
        applyStimulus(8'd2, 1'b0);
        sendWord(6'd0, 32'h8C010000, -1);
        sendWord(6'd1, 32'h20020005, -1);
        endStream();
        waitFinish(latency);
        checkSuccess("gap");
        gapMode = 1'b0;

        $display("[TB] invalid lengths");
        badLength(8'd0, "len0");
        badLength(8'd65, "len65");

        $display("[TB] recovery with one word");
        startLoad();
        checkOutput("recover_err_cleared", 32'(err), 32'd0);
        applyStimulus(8'd1, 1'b0);
        sendWord(6'd0, 32'h00000001, -1);
        endStream();
        waitFinish(latency);
        checkOutput("one_word_latency", 32'(latency), 32'd6);
        checkSuccess("recover");

        $display("[TB] full-depth load");
        startLoad();
        applyStimulus(8'd64, 1'b0);
        for (int i = 0; i < 64; i++) sendWord(6'(i), 32'(i), -1);
        endStream();
        waitFinish(latency);
        checkOutput("full_latency", 32'(latency), 32'd321);
        repeat (20) @(posedge clk);
        #1;
        checkSuccess("full");
        checkOutput("full_last_wa", 32'(ifc.wa), 32'd63);
        checkOutput("full_last_wd", ifc.wd, 32'd63);

        $display("[TB] start pulsed mid-word");
        startLoad();
        applyStimulus(8'd2, 1'b0);
        sendWord(6'd0, 32'h8C010000, 2);
        sendWord(6'd1, 32'h20020005, -1);
        endStream();
        waitFinish(latency);
        checkOutput("midstart_latency", 32'(latency), 32'd11);
        checkSuccess("midstart");

        $display("[TB] reset during load");
        startLoad();
        applyStimulus(8'd2, 1'b0);
        applyStimulus(8'h12, 1'b0);
        applyStimulus(8'h34, 1'b0);
        reset_n = 1'b0;
        endStream();
        #1;
        checkResetValues("midreset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        startLoad();
        applyStimulus(8'd1, 1'b0);
        sendWord(6'd0, 32'hDEADBEEF, -1);
        endStream();
        waitFinish(latency);
        checkSuccess("after_reset");

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the 64-word instruction memory. It receives a length-prefixed byte stream over a valid/ready handshake and assembles the bytes MSB-first into 32-bit instruction words. Each word goes out on a single-cycle write port, `we`/`wa`/`wd`, at consecutive word addresses starting from 0. The core is held in reset until the image is fully written, so instructions can be loaded without the `memfile.dat` preload.

## Interface
- `AW`, 6, word-address width.
- `DEPTH`, 64, number of words in instruction memory; must equal 2**AW.
- `clk`  in  1  single system clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `in_valid`  in  1  byte present on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `we`  out  1  instruction memory write enable, one cycle per word.
- `wa`  out  AW  word address for the write.
- `wd`  out  32  instruction word for the write.
- `busy`  out  1  load in progress (states LEN, DATA, WRITE).
- `done`  out  1  last load completed successfully; sticky until next `start` or reset.
- `err`  out  1  last load rejected due to a bad length; sticky until next `start` or reset.
- `cpu_hold`  out  1  active-high hold/reset request to the processor.

## Operation
- A byte transfers on a rising edge when `in_valid && in_ready`. Neither signal may depend combinationally on the other.
- Stream format: one length byte L (number of words), followed by 4·L data bytes. Each word is sent MSB first: the first byte lands in `wd[31:24]`, the fourth in `wd[7:0]`.
- Valid L is 1..DEPTH. L=0 or L>DEPTH → ERR.
- States:
  - IDLE: `in_ready`=0. `start` → LEN.
  - LEN: `in_ready`=1. On transfer, check L. If valid, latch L, clear address and byte counter → DATA. If invalid → ERR.
  - DATA: `in_ready`=1. Each transfer shifts the word register left by 8 and inserts `in_data`. The byte counter counts 0..3. On the 4th transfer → WRITE.
  - WRITE: `in_ready`=0, `we`=1, `wa`=current address, `wd`=assembled word; lasts one cycle. Then address increments. If address+1 == L → DONE, else → DATA with byte counter = 0.
  - DONE: `done`=1, `cpu_hold`=0. `start` → LEN, which sets `cpu_hold`=1 and clears `done`.
  - ERR: `err`=1, `cpu_hold`=1. `start` → LEN and clears `err`.
- `start` in LEN, DATA or WRITE is ignored; it has no effect on the counters.
- Address arithmetic is AW bits wide. The length compare uses AW+1 bits so L=DEPTH terminates correctly without wrapping to 0.
- `wa` and `wd` hold their last values outside WRITE. Only `we` qualifies them.
- No readback path. The processor reads the memory through its normal port once `cpu_hold` drops.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `we`=0, `wa`=0, `wd`=0, `busy`=0, `done`=0, `err`=0, `cpu_hold`=1.
- `cpu_hold` is 1 from reset until the DONE state is entered. It deasserts on the same edge that sets `done`.
- `start` sampled at edge t → state LEN and `in_ready`=1 from t+1.
- Latency per word is 4 accepted bytes plus 1 WRITE cycle. With `in_valid` held high, each word costs 5 cycles. A full L-word load costs 1 + 5·L cycles after LEN is entered.
- `we` rises the cycle after the 4th byte of a word is accepted. The word is committed to memory at the end of that cycle.
- With L words, the last `we` is at address L-1. DONE is entered on the edge that ends that WRITE cycle.
- Gaps in `in_valid` stall the FSM indefinitely; no timeout.
- Reset mid-load aborts immediately, returns all outputs to reset values, and keeps `cpu_hold`=1. Partially written memory contents are not cleared.

## Test plan
- Reset, then pulse `start`; stream L=2 followed by 8C010000 and 20020005 with `in_valid` held high → `we` pulses at `wa`=0 with `wd`=8C010000 and at `wa`=1 with `wd`=20020005. `done`=1 and `cpu_hold`=0 exactly 11 cycles after LEN is entered.
- Same stream with `in_valid` toggling every other cycle → identical writes, no lost or duplicated bytes, and `in_ready`=0 during each WRITE.
- L=0, and separately L=65 → `err`=1, `cpu_hold`=1, no `we` pulse. A subsequent `start` with L=1 and word 00000001 → `err` clears, one write at `wa`=0, `done`=1.
- L=64 with word value = index → 64 writes at `wa`=0..63, `wd`=0..63; no write occurs after address 63, and `done`=1.
- `start` pulsed mid-word during a load → ignored; the write sequence is unchanged.
- `reset_n` asserted after the 2nd byte of word 1 → all outputs at reset values on assertion. A fresh load afterwards begins at `wa`=0.
